// File: rtl/dump_unit.sv
// dump_unit -- memory read-back engine, the DMA counterpart of the loader.
//
// Once the arbiter grants the shared UART, the block takes a 16-bit word count
// (high byte first) from RX. It then reads that many 32-bit words from the
// selected memory, starting at address 0, and sends each word on TX as four
// bytes, least significant byte first. A completion byte (ACK_DUMP) follows,
// and done is then held until the arbiter withdraws the grant.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   grant_i              arbiter enable, high for the whole transaction
//   target_select_i      0 = IMEM, 1 = DMEM; used by the memory mux outside
//   done_o               completion level to the arbiter
//   rx_data_i/rx_ready_i gated UART RX byte and its one-cycle strobe
//   tx_data_o/tx_start_o byte to transmit and its one-cycle start pulse
//   tx_done_i            one-cycle pulse when the UART TX finishes a byte
//   mem_read_enable_o    read strobe of the synchronous (1-cycle) memory
//   mem_addr_o           read address
//   mem_data_i           read data
module dump_unit #(
  parameter logic [7:0] ACK_DUMP = 8'hF2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        grant_i,
  input  logic        target_select_i,
  output logic        done_o,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_done_i,
  output logic        mem_read_enable_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SIZE_HIGH,
    S_SIZE_LOW,
    S_READ_REQ,
    S_READ_LATCH,
    S_SEND_BYTE,
    S_WAIT_BYTE,
    S_SEND_ACK,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] addr;
  logic [15:0] words_sent;
  logic [15:0] word_count;
  logic [1:0]  byte_index;
  logic [31:0] word_buffer;
  logic [15:0] words_next;
  logic [7:0]  cur_byte;

  // The memory mux outside this block consumes the target select directly.
  logic unused_target_select;
  assign unused_target_select = target_select_i;

  assign words_next = words_sent + 16'd1;
  assign mem_addr_o = addr;

  // Select the byte of the buffered word that is currently being sent.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_index)
      2'd0:    cur_byte = word_buffer[7:0];
      2'd1:    cur_byte = word_buffer[15:8];
      2'd2:    cur_byte = word_buffer[23:16];
      2'd3:    cur_byte = word_buffer[31:24];
      default: cur_byte = 8'h00;
    endcase
  end

  // Transaction FSM with its address, counter and word buffer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      addr        <= 32'd0;
      words_sent  <= 16'd0;
      word_count  <= 16'd0;
      byte_index  <= 2'd0;
      word_buffer <= 32'd0;
    end else if (!grant_i && (state != S_IDLE) && (state != S_DONE)) begin
      // Grant withdrawn mid-transaction: abandon silently. Any byte already
      // handed to the UART finishes on its own and its tx_done is ignored.
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_i) begin
            addr       <= 32'd0;
            words_sent <= 16'd0;
            byte_index <= 2'd0;
            state      <= S_SIZE_HIGH;
          end
        end
        S_SIZE_HIGH: begin
          if (rx_ready_i) begin
            word_count[15:8] <= rx_data_i;
            state            <= S_SIZE_LOW;
          end
        end
        S_SIZE_LOW: begin
          if (rx_ready_i) begin
            word_count[7:0] <= rx_data_i;
            // Decide on the assembled count, not the register still being written.
            if ({word_count[15:8], rx_data_i} == 16'd0) begin
              state <= S_SEND_ACK;
            end else begin
              state <= S_READ_REQ;
            end
          end
        end
        S_READ_REQ: begin
          state <= S_READ_LATCH;
        end
        S_READ_LATCH: begin
          word_buffer <= mem_data_i;
          byte_index  <= 2'd0;
          state       <= S_SEND_BYTE;
        end
        S_SEND_BYTE: begin
          state <= S_WAIT_BYTE;
        end
        S_WAIT_BYTE: begin
          if (tx_done_i) begin
            if (byte_index == 2'd3) begin
              addr       <= addr + 32'd4;
              words_sent <= words_next;
              if (words_next == word_count) begin
                state <= S_SEND_ACK;
              end else begin
                state <= S_READ_REQ;
              end
            end else begin
              byte_index <= byte_index + 2'd1;
              state      <= S_SEND_BYTE;
            end
          end
        end
        S_SEND_ACK: begin
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (tx_done_i) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!grant_i) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore output decode; the data byte stays stable while the UART is busy.
  always_comb begin
    tx_start_o        = 1'b0;
    tx_data_o         = 8'h00;
    mem_read_enable_o = 1'b0;
    done_o            = 1'b0;
    case (state)
      S_READ_REQ:  mem_read_enable_o = 1'b1;
      S_SEND_BYTE: begin
        tx_start_o = 1'b1;
        tx_data_o  = cur_byte;
      end
      S_WAIT_BYTE: tx_data_o = cur_byte;
      S_SEND_ACK: begin
        tx_start_o = 1'b1;
        tx_data_o  = ACK_DUMP;
      end
      S_WAIT_ACK:  tx_data_o = ACK_DUMP;
      S_DONE:      done_o = 1'b1;
      default: begin
        tx_start_o        = 1'b0;
        tx_data_o         = 8'h00;
        mem_read_enable_o = 1'b0;
        done_o            = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dump_unit.sv
// Directed bench for dump_unit: synchronous IMEM/DMEM model, a UART TX model
// that answers each start pulse with tx_done 10 cycles later, and optional
// spurious rx_ready / tx_done pulses while a dump is running.
module tb_dump_unit;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        grant = 1'b0;
  logic        target_select = 1'b0;
  logic        done;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready_t = 1'b0;
  logic        rx_spur = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        model_done = 1'b0;
  logic        spur_done = 1'b0;
  logic        tx_done;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = 32'd0;

  assign rx_ready = rx_ready_t | rx_spur;
  assign tx_done  = model_done | spur_done;

  dump_unit #(.ACK_DUMP(8'hF2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .grant_i(grant), .target_select_i(target_select),
    .done_o(done), .rx_data_i(rx_data), .rx_ready_i(rx_ready),
    .tx_data_o(tx_data), .tx_start_o(tx_start), .tx_done_i(tx_done),
    .mem_read_enable_o(mem_re), .mem_addr_o(mem_addr), .mem_data_i(mem_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  logic [7:0]  tx_log [$];
  logic [31:0] rd_log [$];
  logic        rd_pend = 1'b0;
  logic [31:0] rd_addr = 32'd0;
  int          tx_cnt = 0;
  int          spur_cnt = 0;
  int          cyc = 0;
  bit          spur_en = 1'b0;

  // Synchronous memory: data for a request seen in one cycle appears the next.
  always @(posedge clk) begin
    if (rd_pend) mem_data <= target_select ? dmem[rd_addr[9:2]] : imem[rd_addr[9:2]];
  end

  // Monitors, UART TX model and spurious-pulse injector, all on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    rd_pend = mem_re;
    rd_addr = mem_addr;
    if (mem_re) rd_log.push_back(mem_addr);
    model_done = 1'b0;
    if (tx_cnt != 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) model_done = 1'b1;
    end
    if (tx_start) begin
      tx_log.push_back(tx_data);
      tx_cnt = 10;
    end
    // tx_done pulses during READ_REQ, READ_LATCH and SEND_BYTE of every word.
    if (spur_en && mem_re) spur_cnt = 3;
    if (spur_cnt > 0) begin
      spur_done = 1'b1;
      spur_cnt = spur_cnt - 1;
    end else begin
      spur_done = 1'b0;
    end
    rx_spur = spur_en && ((cyc % 7) == 0);
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_txn(input logic sel);
    for (int i = 0; i < 100 && tx_cnt != 0; i++) tick();
    tx_log.delete();
    rd_log.delete();
    target_select = sel;
    grant = 1'b1;
  endtask

  // Ends one cycle after the low size byte was sampled (cycle N+1).
  task automatic send_size(input logic [15:0] c);
    tick();
    rx_data = c[15:8];
    rx_ready_t = 1'b1;
    tick();
    rx_ready_t = 1'b0;
    tick();
    rx_data = c[7:0];
    rx_ready_t = 1'b1;
    tick();
    rx_ready_t = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      if (done) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic end_txn();
    grant = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL reset_mem_re got %b want 0", mem_re); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    tick();
    rst_ni = 1'b1;
    tick(2);
  endtask

  task automatic test_two_words();
    logic [7:0] exp_b [9] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'hF2};
    bit ok;
    start_txn(1'b0);
    send_size(16'h0002);
    checks++; if (mem_re !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL two_read_at_n1 got re=%b addr=%h want re=1 addr=0", mem_re, mem_addr); end
    tick(2);
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h44) begin failures++; $display("FAIL two_first_start_n3 got start=%b data=%h want 1/44", tx_start, tx_data); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL two_done_early got %b want 0", done); end
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL two_done_timeout got %b want 1", ok); end
    checks++; if (tx_cnt !== 0) begin failures++; $display("FAIL two_done_before_ack_end got busy=%0d want 0", tx_cnt); end
    checks++; if (tx_log.size() !== 9) begin failures++; $display("FAIL two_byte_count got %0d want 9", tx_log.size()); end
    for (int i = 0; i < 9 && i < tx_log.size(); i++) begin
      checks++; if (tx_log[i] !== exp_b[i]) begin failures++; $display("FAIL two_byte[%0d] got %h want %h", i, tx_log[i], exp_b[i]); end
    end
    checks++; if (rd_log.size() !== 2) begin failures++; $display("FAIL two_read_count got %0d want 2", rd_log.size()); end
    else begin
      checks++; if (rd_log[0] !== 32'h0 || rd_log[1] !== 32'h4) begin failures++; $display("FAIL two_read_addr got %h,%h want 0,4", rd_log[0], rd_log[1]); end
    end
    end_txn();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL two_done_release got %b want 0", done); end
  endtask

  task automatic test_zero_count();
    bit ok;
    start_txn(1'b0);
    send_size(16'h0000);
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'hF2) begin failures++; $display("FAIL zero_ack_start got start=%b data=%h want 1/F2", tx_start, tx_data); end
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL zero_done_timeout got %b want 1", ok); end
    checks++; if (tx_log.size() !== 1) begin failures++; $display("FAIL zero_byte_count got %0d want 1", tx_log.size()); end
    else begin
      checks++; if (tx_log[0] !== 8'hF2) begin failures++; $display("FAIL zero_ack_byte got %h want F2", tx_log[0]); end
    end
    checks++; if (rd_log.size() !== 0) begin failures++; $display("FAIL zero_reads got %0d want 0", rd_log.size()); end
    end_txn();
  endtask

  task automatic test_dmem_256();
    bit ok;
    logic [31:0] w;
    for (int i = 0; i < 256; i++) dmem[i] = 32'hDEAD0000 | 32'(i * 4);
    start_txn(1'b1);
    send_size(16'h0100);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL dmem_done_timeout got %b want 1", ok); end
    checks++; if (tx_log.size() !== 1025) begin failures++; $display("FAIL dmem_byte_count got %0d want 1025", tx_log.size()); end
    else begin
      for (int i = 0; i < 256; i++) begin
        w = 32'hDEAD0000 | 32'(i * 4);
        for (int b = 0; b < 4; b++) begin
          checks++; if (tx_log[4*i+b] !== 8'((w >> (8*b)) & 32'hFF)) begin
            failures++; $display("FAIL dmem_byte[%0d] got %h want %h", 4*i+b, tx_log[4*i+b], 8'((w >> (8*b)) & 32'hFF));
          end
        end
      end
      checks++; if (tx_log[1024] !== 8'hF2) begin failures++; $display("FAIL dmem_ack got %h want F2", tx_log[1024]); end
    end
    checks++; if (rd_log.size() !== 256) begin failures++; $display("FAIL dmem_read_count got %0d want 256", rd_log.size()); end
    else begin
      for (int i = 0; i < 256; i++) begin
        checks++; if (rd_log[i] !== 32'(i * 4)) begin failures++; $display("FAIL dmem_read_addr[%0d] got %h want %h", i, rd_log[i], 32'(i * 4)); end
      end
      checks++; if (rd_log[255] !== 32'h3FC) begin failures++; $display("FAIL dmem_last_addr got %h want 3FC", rd_log[255]); end
    end
    end_txn();
  endtask

  task automatic test_abort();
    bit ok;
    start_txn(1'b0);
    send_size(16'h0002);
    for (int i = 0; i < 2000 && tx_log.size() < 5; i++) tick();
    checks++; if (tx_log.size() !== 5) begin failures++; $display("FAIL abort_reach_word1 got %0d want 5", tx_log.size()); end
    tick();
    checks++; if (tx_data !== 8'hDD) begin failures++; $display("FAIL abort_wait_byte got %h want DD", tx_data); end
    grant = 1'b0;
    tick();
    checks++; if (tx_data !== 8'h00 || tx_start !== 1'b0 || mem_re !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL abort_idle got data=%h start=%b re=%b done=%b want 00/0/0/0", tx_data, tx_start, mem_re, done);
    end
    tick(30);
    checks++; if (tx_log.size() !== 5 || done !== 1'b0) begin failures++; $display("FAIL abort_no_ack got bytes=%0d done=%b want 5/0", tx_log.size(), done); end
    start_txn(1'b0);
    send_size(16'h0002);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL abort_retry_timeout got %b want 1", ok); end
    checks++; if (tx_log.size() !== 9 || tx_log[0] !== 8'h44 || tx_log[8] !== 8'hF2) begin failures++; $display("FAIL abort_retry_stream got n=%0d first=%h want 9/44", tx_log.size(), tx_log[0]); end
    checks++; if (rd_log.size() !== 2 || rd_log[0] !== 32'h0) begin failures++; $display("FAIL abort_retry_addr got n=%0d first=%h want 2/0", rd_log.size(), rd_log[0]); end
    end_txn();
  endtask

  task automatic test_spurious();
    bit ok;
    logic [7:0] exp_b [9] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'hF2};
    start_txn(1'b0);
    send_size(16'h0002);
    spur_en = 1'b1;
    wait_done(ok);
    spur_en = 1'b0;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL spur_done_timeout got %b want 1", ok); end
    checks++; if (tx_log.size() !== 9) begin failures++; $display("FAIL spur_byte_count got %0d want 9", tx_log.size()); end
    for (int i = 0; i < 9 && i < tx_log.size(); i++) begin
      checks++; if (tx_log[i] !== exp_b[i]) begin failures++; $display("FAIL spur_byte[%0d] got %h want %h", i, tx_log[i], exp_b[i]); end
    end
    checks++; if (rd_log.size() !== 2 || rd_log[0] !== 32'h0 || rd_log[1] !== 32'h4) begin failures++; $display("FAIL spur_reads got n=%0d want 2 reads at 0,4", rd_log.size()); end
    end_txn();
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_txn(1'b0);
    send_size(16'h0002);
    for (int i = 0; i < 2000 && tx_log.size() < 6; i++) tick();
    tick();
    checks++; if (mem_addr !== 32'h4 || tx_data !== 8'hCC) begin failures++; $display("FAIL rstmid_pre got addr=%h data=%h want 4/CC", mem_addr, tx_data); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (tx_data !== 8'h00 || tx_start !== 1'b0 || mem_re !== 1'b0 || done !== 1'b0 || mem_addr !== 32'h0) begin
      failures++; $display("FAIL rstmid_outputs got data=%h start=%b re=%b done=%b addr=%h want all 0", tx_data, tx_start, mem_re, done, mem_addr);
    end
    grant = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    start_txn(1'b0);
    send_size(16'h0000);
    wait_done(ok);
    checks++; if (ok !== 1'b1 || tx_log.size() !== 1 || rd_log.size() !== 0) begin failures++; $display("FAIL rstmid_after got ok=%b bytes=%0d reads=%0d want 1/1/0", ok, tx_log.size(), rd_log.size()); end
    end_txn();
  endtask

  initial begin
    imem[0] = 32'h11223344;
    imem[1] = 32'hAABBCCDD;
    test_reset();
    test_two_words();
    test_zero_count();
    test_dmem_256();
    test_abort();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/dump_unit.md
# dump_unit

Memory read-back engine, the DMA counterpart of the program/data loader. When granted by the arbiter, it receives a 16-bit word count over UART RX and reads that many 32-bit words from the selected memory, starting at address 0. It transmits each word over UART TX as four bytes, least significant byte first, then sends a completion byte and signals the arbiter. It shares the arbiter, gated-RX and multiplexed-TX interfaces with the loader and drives a read-only memory port.

## Interface

Parameters:
- ACK_DUMP, 8'hF2, completion byte sent after the last payload byte.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- grant_i  input  1  arbiter enable; held high for the whole transaction.
- target_select_i  input  1  0 = IMEM, 1 = DMEM. Forwarded unchanged to the memory mux outside this block.
- done_o  output  1  completion flag to the arbiter.
- rx_data_i  input  8  UART RX byte.
- rx_ready_i  input  1  one-cycle strobe; rx_data_i is valid while it is high.
- tx_data_o  output  8  byte to transmit.
- tx_start_o  output  1  one-cycle start pulse to the UART TX.
- tx_done_i  input  1  one-cycle pulse when the UART TX finishes a byte.
- mem_read_enable_o  output  1  read strobe.
- mem_addr_o  output  32  read address.
- mem_data_i  input  32  read data. Synchronous memory: valid exactly 1 cycle after the address is presented with mem_read_enable_o high.

## Operation

States:
- S_IDLE. On grant_i: clear addr, words_sent, byte_index; go to S_SIZE_HIGH.
- S_SIZE_HIGH. On rx_ready_i: word_count[15:8] = rx_data_i; go to S_SIZE_LOW.
- S_SIZE_LOW. On rx_ready_i: word_count[7:0] = rx_data_i.
  - If the assembled count is 0, go to S_SEND_ACK.
  - Otherwise go to S_READ_REQ.
- S_READ_REQ. mem_read_enable_o = 1 and mem_addr_o = addr; go to S_READ_LATCH.
- S_READ_LATCH. word_buffer = mem_data_i; byte_index = 0; go to S_SEND_BYTE.
- S_SEND_BYTE. tx_start_o = 1; tx_data_o = word_buffer[8*byte_index +: 8]; go to S_WAIT_BYTE.
- S_WAIT_BYTE. tx_data_o is held. On tx_done_i:
  - If byte_index = 3: addr += 4 and words_sent += 1. If the new words_sent equals word_count, go to S_SEND_ACK; otherwise go to S_READ_REQ.
  - Otherwise byte_index += 1 and go to S_SEND_BYTE.
- S_SEND_ACK. tx_start_o = 1; tx_data_o = ACK_DUMP; go to S_WAIT_ACK.
- S_WAIT_ACK. tx_data_o = ACK_DUMP is held. On tx_done_i, go to S_DONE.
- S_DONE. done_o = 1 (level). When grant_i is low, go to S_IDLE.

Rules:
- Counters are 16-bit unsigned. The maximum count of 65535 words yields a final address of 0x3FFFC.
- Address arithmetic is 32-bit, unsigned, and never wraps in range.
- grant_i low in any state other than S_IDLE or S_DONE aborts the transaction:
  - Next state is S_IDLE.
  - No ACK is sent and done_o is not asserted.
  - Any TX byte already in flight is left to complete; its tx_done_i is ignored.
- rx_ready_i is ignored in every state except S_SIZE_HIGH and S_SIZE_LOW. RX bytes arriving mid-dump are dropped.
- tx_done_i is sampled only in S_WAIT_BYTE and S_WAIT_ACK.
- mem_read_enable_o is asserted only in S_READ_REQ.

## Timing

- Reset values: all outputs 0, state S_IDLE, all counters and buffers 0.
- Outputs other than the memory address are combinational from state (Moore). mem_addr_o = addr in all states.
- Latency from grant_i rising to S_SIZE_HIGH: 1 cycle.
- From the low size byte strobe (cycle N), per word:
  - Read request at N+1.
  - Data latched at N+2.
  - First tx_start_o at N+3.
- After a word's final tx_done_i (cycle M): next read at M+1 and next tx_start_o at M+3.
- After a byte's tx_done_i (cycle M) within a word: next tx_start_o at M+1.
- tx_start_o is exactly one cycle wide per byte. Exactly 4·count + 1 pulses occur per completed transaction.

## Test plan

- Count 0x0002, IMEM words [0]=0x11223344 and [1]=0xAABBCCDD, TX model returns tx_done 10 cycles after start:
  - TX stream is 44 33 22 11 DD CC BB AA F2.
  - Reads occur at addresses 0x0 and 0x4 only.
  - done_o rises after the F2 byte completes.
- Count 0x0000 → the only TX byte is F2; there are no memory reads; done_o is asserted.
- Count 0x0100 with DMEM filled by an address pattern → 1024 bytes, little-endian, matching the pattern; last read address 0x3FC; then F2.
- grant_i dropped while in S_WAIT_BYTE of word 1:
  - Returns to S_IDLE the next cycle.
  - No F2 is sent; done_o stays 0.
  - A second full transaction afterwards starts at address 0.
- Spurious rx_ready_i pulses and tx_done_i pulses outside the wait states during a dump → TX stream and address sequence unchanged.
- rst_ni asserted mid-dump → all outputs 0 immediately (asynchronous); state S_IDLE.
